ula_param: RTL and testbench
============================

# ula_param

Parametrised, pipelined successor to the team's 8-bit ULA: a WIDTH-bit arithmetic/logic unit with a valid/ready input handshake, full registered flag set, shift operations and an optional iterative shift-add multiplier. Operands are captured in an input stage and results in an output stage, so single-cycle operations sustain one result per clock. It sits between the operand/opcode source and the result consumer in the datapath and replaces the fixed 8-bit unit.

## Interface
- WIDTH, 8: operand and result width in bits; minimum 2.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B (ignored by SHL/SHR).
- opcode_in  input  3  operation select.
- valid_in  input  1  operand/opcode presented.
- ready_in  output  1  unit can accept; transfer occurs on an edge with valid_in && ready_in.
- s  output  WIDTH  registered result.
- valid_out  output  1  one-cycle pulse: s/flags updated on the preceding edge.
- carry  output  1  carry/borrow/shifted-out bit.
- zero  output  1  s == 0.
- negativo  output  1  s[WIDTH-1].
- overflow  output  1  signed overflow (ADD/SUB) or product overflow (MUL).

## Operation
- Opcodes: 000 ADD, 001 SUB (a−b), 010 AND, 011 OR, 100 XOR, 101 SHL by 1 (a), 110 SHR by 1 logical (a), 111 MUL (unsigned a×b).
- Input stage: on accept, a_r, b_r, op_r loaded, v_r set; otherwise v_r cleared.
- Output stage, single-cycle ops (v_r and op_r ≠ MUL): s and all four flags written, valid_out = 1.
- ADD: s = low WIDTH bits of a+b; carry = bit WIDTH of sum; overflow = operands same sign, result sign differs.
- SUB: s = a−b mod 2^WIDTH; carry = borrow (a < b unsigned); overflow = operand signs differ, result sign ≠ a sign.
- AND/OR/XOR: carry = 0, overflow = 0.
- SHL: carry = a[WIDTH-1], s = {a[WIDTH-2:0],0}; SHR: carry = a[0], s = {0,a[WIDTH-1:1]}; overflow = 0.
- zero and negativo always derived from the new s.
- Flags and s hold their values between results.
- FSM: IDLE, MUL.
  - IDLE → MUL when v_r && op_r == MUL; loads multiplicand, multiplier, 2·WIDTH-bit accumulator = 0, counter = WIDTH.
  - MUL: one shift-add step per cycle, counter decrements; on the step where counter reaches 0, writes s = product[WIDTH-1:0], carry = overflow = |product[2WIDTH-1:WIDTH], zero/negativo from s, valid_out = 1; returns to IDLE.
- ready_in = (state == IDLE) && !(v_r && op_r == MUL) (combinational).
- valid_in while ready_in = 0: not accepted, no side effects; source must hold.
- Reset: s = 0, carry = zero = negativo = overflow = 0, valid_out = 0, v_r = 0, FSM IDLE; ready_in = 1 in the cycle after reset deasserts. Reset during MUL aborts; no valid_out for the aborted operation.
- Reset and valid_in on the same edge: reset wins, operand discarded.

## Timing
- Single-cycle op accepted on edge N: s/flags written on edge N+1; valid_out high during cycle N+1→N+2.
- Back-to-back single-cycle ops: one accept and one valid_out per cycle, ready_in stays 1.
- MUL accepted on edge N: ready_in low from edge N to edge N+WIDTH+1; result written on edge N+WIDTH+1; ready_in high again in that cycle; next op accepted earliest at edge N+WIDTH+2.
- A single-cycle op accepted at N−1 followed by MUL at N: both produce results, in order.

## Configuration
- ULA_MUL_EN defined: multiplier, FSM and MUL behaviour as above.
- ULA_MUL_EN undefined: no multiplier or FSM; ready_in tied to 1; opcode 111 treated as single-cycle: s = 0, zero = 1, carry = negativo = overflow = 0, valid_out on edge N+1.

## Test plan
- WIDTH=8, ADD 0xFF+0x01 → s=0x00, carry=1, zero=1, overflow=0, valid_out one cycle after accept edge.
- ADD 0x7F+0x01 → s=0x80, overflow=1, negativo=1, carry=0; SUB 0x05−0x07 → s=0xFE, carry=1, negativo=1, overflow=0.
- AND, OR, XOR of 0xF0, 0x3C on three consecutive cycles → s=0x30, 0xFC, 0xCC on three consecutive valid_out cycles.
- SHL 0x81 → s=0x02, carry=1; SHR 0x01 → s=0x00, carry=1, zero=1.
- MUL 0x10×0x10 (ULA_MUL_EN) → ready_in low 9 edges, s=0x00, carry=overflow=1, zero=1 on edge N+9; valid_in held during busy produces no extra result.
- rst at cycle 4 of MUL 0x0F×0x03 → no valid_out, s=0, flags 0, ready_in=1 next cycle; following ADD 0x01+0x01 → s=0x02.

Source files
------------

// File: rtl/ula_param.sv
// ula_param: WIDTH-bit pipelined ALU with valid/ready input, registered flags.
// Ports: clk, rst (sync, active-high); a_in, b_in, opcode_in, valid_in in;
//   ready_in, s, valid_out, carry, zero, negativo, overflow out.
// Build option: ULA_MUL_EN enables the iterative shift-add multiplier (op 111).
module ula_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       opcode_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [WIDTH-1:0] s,
    output logic             valid_out,
    output logic             carry,
    output logic             zero,
    output logic             negativo,
    output logic             overflow
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic             v_q;
    logic             accept;

    assign accept = valid_in && ready_in;

    // Input stage
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_ADD;
        end else begin
            v_q <= accept;
            if (accept) begin
                a_q  <= a_in;
                b_q  <= b_in;
                op_q <= opcode_in;
            end
        end
    end

    // Single-cycle datapath
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] res_d;
    logic             c_d, ov_d;

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    // Bit WIDTH of the extended difference is the unsigned borrow
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        ov_d  = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                ov_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = diff[WIDTH-1:0];
                c_d   = diff[WIDTH];
                ov_d  = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                        (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: res_d = a_q & b_q;
            OP_OR:  res_d = a_q | b_q;
            OP_XOR: res_d = a_q ^ b_q;
            OP_SHL: begin
                res_d = {a_q[WIDTH-2:0], 1'b0};
                c_d   = a_q[WIDTH-1];
            end
            OP_SHR: begin
                res_d = {1'b0, a_q[WIDTH-1:1]};
                c_d   = a_q[0];
            end
            OP_MUL: begin
                res_d = '0;
            end
        endcase
    end

`ifdef ULA_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q;
    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_step;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               mul_pend;

    assign mul_pend = v_q && (op_q == OP_MUL);
    assign ready_in = (state_q == S_IDLE) && !mul_pend;
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Control FSM plus output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            s         <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            negativo  <= 1'b0;
            overflow  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (v_q && !mul_pend) begin
                        s         <= res_d;
                        carry     <= c_d;
                        overflow  <= ov_d;
                        zero      <= (res_d == '0);
                        negativo  <= res_d[WIDTH-1];
                        valid_out <= 1'b1;
                    end else if (mul_pend) begin
                        mcand_q  <= {{WIDTH{1'b0}}, a_q};
                        mplier_q <= b_q;
                        acc_q    <= '0;
                        cnt_q    <= CW'(WIDTH);
                        state_q  <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    // Last step: acc_step already holds the full product
                    if (cnt_q == CW'(1)) begin
                        s         <= acc_step[WIDTH-1:0];
                        carry     <= |acc_step[2*WIDTH-1:WIDTH];
                        overflow  <= |acc_step[2*WIDTH-1:WIDTH];
                        zero      <= (acc_step[WIDTH-1:0] == '0);
                        negativo  <= acc_step[WIDTH-1];
                        valid_out <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
            endcase
        end
    end
`else
    assign ready_in = 1'b1;

    // Output stage; opcode 111 yields the all-zero result from res_d
    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            negativo  <= 1'b0;
            overflow  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= v_q;
            if (v_q) begin
                s        <= res_d;
                carry    <= c_d;
                overflow <= ov_d;
                zero     <= (res_d == '0);
                negativo <= res_d[WIDTH-1];
            end
        end
    end
`endif

endmodule

// File: tb/tb_ula_param.sv
// tb_ula_param: directed plus random stimulus for ula_param, checked against
// an arithmetic reference model with a queue of pending results.
module tb_ula_param;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [2:0]   opcode_in = '0;
    logic         valid_in = 1'b0;
    logic         ready_in;
    logic [W-1:0] s;
    logic         valid_out, carry, zero, negativo, overflow;

    always #5 clk = ~clk;

    ula_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .opcode_in (opcode_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .s         (s),
        .valid_out (valid_out),
        .carry     (carry),
        .zero      (zero),
        .negativo  (negativo),
        .overflow  (overflow)
    );

    typedef struct {
        int           due;
        bit           mul;
        logic [W-1:0] s;
        logic         c, z, n, v;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    bit   acc_last = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h edge=%0d",
                   tag, obs, exp, edge_n);
        end
    endtask

    function automatic exp_t model(int a, int b, int op);
        exp_t e;
        int   r;
        e.c = 0;
        e.v = 0;
        e.mul = 0;
        e.due = 0;
        r = 0;
        case (op)
            0: begin
                r = a + b;
                e.c = (r >= M);
                r = r % M;
                e.v = ((a >= M/2) == (b >= M/2)) && ((r >= M/2) != (a >= M/2));
            end
            1: begin
                r = (a - b + M) % M;
                e.c = (a < b);
                e.v = ((a >= M/2) != (b >= M/2)) && ((r >= M/2) != (a >= M/2));
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin
                r = (a * 2) % M;
                e.c = (a >= M/2);
            end
            6: begin
                r = a / 2;
                e.c = a % 2;
            end
            default: begin
`ifdef ULA_MUL_EN
                r = a * b;
                e.c = (r >= M);
                e.v = (r >= M);
                r = r % M;
                e.mul = 1;
`else
                r = 0;
`endif
            end
        endcase
        e.s = r[W-1:0];
        e.z = (r == 0);
        e.n = (r >= M/2);
        return e;
    endfunction

    // One clock: update the model on the edge, check the DUT on the negedge
    task automatic tick();
        bit   acc, r, rdy;
        int   a, b, op;
        bit   vo;
        exp_t e;
        acc = valid_in && ready_in && !rst;
        r = rst;
        a = int'(a_in);
        b = int'(b_in);
        op = int'(opcode_in);
        @(posedge clk);
        edge_n++;
        if (r) begin
            q.delete();
            last = '{default: 0};
        end else if (acc) begin
            e = model(a, b, op);
            e.due = edge_n + (e.mul ? W + 1 : 1);
            q.push_back(e);
        end
        acc_last = acc;
        @(negedge clk);
        vo = (q.size() > 0) && (q[0].due == edge_n);
        chk("valid_out", 32'(valid_out), 32'(vo));
        if (vo) last = q.pop_front();
        chk("s", 32'(s), 32'(last.s));
        chk("carry", 32'(carry), 32'(last.c));
        chk("zero", 32'(zero), 32'(last.z));
        chk("negativo", 32'(negativo), 32'(last.n));
        chk("overflow", 32'(overflow), 32'(last.v));
        rdy = 1;
        foreach (q[i]) if (q[i].mul) rdy = 0;
        chk("ready_in", 32'(ready_in), 32'(rdy));
    endtask

    // Present an operation and hold it until accepted (bounded)
    task automatic send(int a, int b, int op);
        a_in = W'(a);
        b_in = W'(b);
        opcode_in = 3'(op);
        valid_in = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (acc_last) break;
        end
        chk("accept", 32'(acc_last), 32'd1);
    endtask

    task automatic idle(int n);
        valid_in = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        last = '{default: 0};
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        send('hFF, 'h01, 0);
        send('h7F, 'h01, 0);
        send('h05, 'h07, 1);
        send('hF0, 'h3C, 2);
        send('hF0, 'h3C, 3);
        send('hF0, 'h3C, 4);
        send('h81, 'h00, 5);
        send('h01, 'h00, 6);
        idle(2);

        send('h10, 'h10, 7);
        send('h01, 'h02, 0);
        idle(12);

        send('h0F, 'h03, 7);
        valid_in = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        a_in = 8'h11;
        b_in = 8'h22;
        opcode_in = 3'b000;
        valid_in = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        valid_in = 1'b0;
        tick();

        send('h01, 'h01, 0);
        idle(2);

        send('h40, 'h01, 7);
        send('h7F, 'h02, 5);
        idle(12);

        for (int i = 0; i < 300; i++) begin
            send(int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                 int'($urandom_range(0, 7)));
            if ($urandom_range(0, 9) < 3) idle(int'($urandom_range(1, 3)));
        end
        idle(W + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
